control_sequencer: RTL and testbench



---
 rtl/control_sequencer_if.sv | 44 ++++
 rtl/control_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the phase-1 datapath.
// The master is the sequencer; the slave is the datapath (or a bench standing in for it).
interface control_sequencer_if #(
    parameter int unsigned NREG = 16
);
    logic [31:0]     IR;
    logic            mem_ready;

    logic            PCout;
    logic            MARin;
    logic            IncPC;
    logic            Zin;
    logic            ZLowout;
    logic            ZHighout;
    logic            PCin;
    logic            Read;
    logic            MDRin;
    logic            MDRout;
    logic            IRin;
    logic            Yin;
    logic            Cout;
    logic            HIin;
    logic            LOin;
    logic [NREG-1:0] Rin;
    logic [NREG-1:0] Rout;
    logic [3:0]      ALUselect;

    logic            run;
    logic            illegal;

    modport master (
        input  IR, mem_ready,
        output PCout, MARin, IncPC, Zin, ZLowout, ZHighout, PCin, Read, MDRin,
               MDRout, IRin, Yin, Cout, HIin, LOin, Rin, Rout, ALUselect,
               run, illegal
    );

    modport slave (
        output IR, mem_ready,
        input  PCout, MARin, IncPC, Zin, ZLowout, ZHighout, PCin, Read, MDRin,
               MDRout, IRin, Yin, Cout, HIin, LOin, Rin, Rout, ALUselect,
               run, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired one-state-per-clock sequencer for the phase-1 datapath: fetch,
// decode of IR, and strobes for reg-reg, immediate, unary and mul/div ops.
module control_sequencer #(
    parameter int unsigned NREG = 16
) (
    input  logic                clk,
    input  logic                reset,
    control_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_RR, CLS_IMM, CLS_MD, CLS_UN, CLS_NOP, CLS_HALT, CLS_ILL
    } op_class_t;

    state_t          state;
    state_t          state_nxt;
    op_class_t       op_class;
    logic [3:0]      alu_op;
    logic [4:0]      opcode;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic [3:0]      rc;
    logic [NREG-1:0] ra_oh;
    logic [NREG-1:0] rb_oh;
    logic [NREG-1:0] rc_oh;
    logic            unused_ir_low;

    assign opcode = bus.IR[31:27];
    assign ra     = bus.IR[26:23];
    assign rb     = bus.IR[22:19];
    assign rc     = bus.IR[18:15];
    assign ra_oh  = NREG'(1) << ra;
    assign rb_oh  = NREG'(1) << rb;
    assign rc_oh  = NREG'(1) << rc;

    // The immediate field is sign-extended by the datapath, not here.
    assign unused_ir_low = ^bus.IR[14:0];

    // Opcode to instruction class and ALU operation.
    always_comb begin
        op_class = CLS_ILL;
        alu_op   = 4'b0000;
        case (opcode)
            5'b00011: begin op_class = CLS_RR;   alu_op = 4'b0000; end
            5'b00100: begin op_class = CLS_RR;   alu_op = 4'b0001; end
            5'b00101: begin op_class = CLS_RR;   alu_op = 4'b0010; end
            5'b00110: begin op_class = CLS_RR;   alu_op = 4'b0011; end
            5'b00111: begin op_class = CLS_RR;   alu_op = 4'b0100; end
            5'b01000: begin op_class = CLS_RR;   alu_op = 4'b0101; end
            5'b01001: begin op_class = CLS_RR;   alu_op = 4'b0110; end
            5'b01010: begin op_class = CLS_RR;   alu_op = 4'b0111; end
            5'b01011: begin op_class = CLS_IMM;  alu_op = 4'b0000; end
            5'b01100: begin op_class = CLS_IMM;  alu_op = 4'b0110; end
            5'b01101: begin op_class = CLS_IMM;  alu_op = 4'b0111; end
            5'b01111: begin op_class = CLS_MD;   alu_op = 4'b1000; end
            5'b10000: begin op_class = CLS_MD;   alu_op = 4'b1001; end
            5'b10001: begin op_class = CLS_UN;   alu_op = 4'b1010; end
            5'b10010: begin op_class = CLS_UN;   alu_op = 4'b1011; end
            5'b11010: begin op_class = CLS_NOP;  alu_op = 4'b0000; end
            5'b11011: begin op_class = CLS_HALT; alu_op = 4'b0000; end
            default:  begin op_class = CLS_ILL;  alu_op = 4'b0000; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_T0;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and strobes; everything stays low while reset is asserted.
    always_comb begin
        state_nxt     = state;
        bus.PCout     = 1'b0;
        bus.MARin     = 1'b0;
        bus.IncPC     = 1'b0;
        bus.Zin       = 1'b0;
        bus.ZLowout   = 1'b0;
        bus.ZHighout  = 1'b0;
        bus.PCin      = 1'b0;
        bus.Read      = 1'b0;
        bus.MDRin     = 1'b0;
        bus.MDRout    = 1'b0;
        bus.IRin      = 1'b0;
        bus.Yin       = 1'b0;
        bus.Cout      = 1'b0;
        bus.HIin      = 1'b0;
        bus.LOin      = 1'b0;
        bus.Rin       = '0;
        bus.Rout      = '0;
        bus.ALUselect = 4'b0000;
        bus.run       = 1'b0;
        bus.illegal   = 1'b0;

        if (!reset) begin
            bus.run = (state != S_HALT);
            case (state)
                S_T0: begin
                    bus.PCout = 1'b1;
                    bus.MARin = 1'b1;
                    bus.IncPC = 1'b1;
                    bus.Zin   = 1'b1;
                    state_nxt = S_T1;
                end
                S_T1: begin
                    bus.ZLowout = 1'b1;
                    bus.PCin    = 1'b1;
                    bus.Read    = 1'b1;
                    bus.MDRin   = 1'b1;
                    state_nxt   = bus.mem_ready ? S_T2 : S_T1;
                end
                S_T2: begin
                    bus.MDRout = 1'b1;
                    bus.IRin   = 1'b1;
                    state_nxt  = S_T3;
                end
                S_T3: begin
                    case (op_class)
                        CLS_RR, CLS_IMM: begin
                            bus.Rout  = rb_oh;
                            bus.Yin   = 1'b1;
                            state_nxt = S_T4;
                        end
                        CLS_MD: begin
                            bus.Rout  = ra_oh;
                            bus.Yin   = 1'b1;
                            state_nxt = S_T4;
                        end
                        CLS_UN: begin
                            bus.Rout      = rb_oh;
                            bus.Zin       = 1'b1;
                            bus.ALUselect = alu_op;
                            state_nxt     = S_T4;
                        end
                        CLS_HALT: state_nxt = S_HALT;
                        CLS_ILL: begin
                            bus.illegal = 1'b1;
                            state_nxt   = S_T0;
                        end
                        default:  state_nxt = S_T0;
                    endcase
                end
                S_T4: begin
                    state_nxt = S_T5;
                    case (op_class)
                        CLS_RR: begin
                            bus.Rout      = rc_oh;
                            bus.Zin       = 1'b1;
                            bus.ALUselect = alu_op;
                        end
                        CLS_IMM: begin
                            bus.Cout      = 1'b1;
                            bus.Zin       = 1'b1;
                            bus.ALUselect = alu_op;
                        end
                        CLS_MD: begin
                            bus.Rout      = rb_oh;
                            bus.Zin       = 1'b1;
                            bus.ALUselect = alu_op;
                        end
                        CLS_UN: begin
                            bus.ZLowout = 1'b1;
                            bus.Rin     = ra_oh;
                            state_nxt   = S_T0;
                        end
                        default: state_nxt = S_T0;
                    endcase
                end
                S_T5: begin
                    state_nxt = S_T0;
                    case (op_class)
                        CLS_RR, CLS_IMM: begin
                            bus.ZLowout = 1'b1;
                            bus.Rin     = ra_oh;
                        end
                        CLS_MD: begin
                            bus.ZLowout = 1'b1;
                            bus.LOin    = 1'b1;
                            state_nxt   = S_T6;
                        end
                        default: state_nxt = S_T0;
                    endcase
                end
                S_T6: begin
                    bus.ZHighout = 1'b1;
                    bus.HIin     = 1'b1;
                    state_nxt    = S_T0;
                end
                S_HALT:  state_nxt = S_HALT;
                default: state_nxt = S_T0;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized and directed bench for control_sequencer; expected per-cycle
// strobe traces are derived from the instruction-level behaviour.
module tb_control_sequencer;

    typedef struct packed {
        logic        run;
        logic        illegal;
        logic        PCout;
        logic        MARin;
        logic        IncPC;
        logic        Zin;
        logic        ZLowout;
        logic        ZHighout;
        logic        PCin;
        logic        Read;
        logic        MDRin;
        logic        MDRout;
        logic        IRin;
        logic        Yin;
        logic        Cout;
        logic        HIin;
        logic        LOin;
        logic [15:0] Rin;
        logic [15:0] Rout;
        logic [3:0]  alu;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   irin_cnt;
    int   read_cnt;
    int   hiin_cnt;

    vec_t exp_q[$];
    logic mr_q[$];

    control_sequencer_if #(.NREG(16)) bus ();

    control_sequencer #(.NREG(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t sample();
        vec_t o;
        o.run      = bus.run;
        o.illegal  = bus.illegal;
        o.PCout    = bus.PCout;
        o.MARin    = bus.MARin;
        o.IncPC    = bus.IncPC;
        o.Zin      = bus.Zin;
        o.ZLowout  = bus.ZLowout;
        o.ZHighout = bus.ZHighout;
        o.PCin     = bus.PCin;
        o.Read     = bus.Read;
        o.MDRin    = bus.MDRin;
        o.MDRout   = bus.MDRout;
        o.IRin     = bus.IRin;
        o.Yin      = bus.Yin;
        o.Cout     = bus.Cout;
        o.HIin     = bus.HIin;
        o.LOin     = bus.LOin;
        o.Rin      = bus.Rin;
        o.Rout     = bus.Rout;
        o.alu      = bus.ALUselect;
        return o;
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] r);
        logic [15:0] one;
        one = 16'd1;
        return one << r;
    endfunction

    // Instruction kind: 0 rr, 1 imm, 2 muldiv, 3 unary, 4 nop, 5 halt, 6 illegal.
    function automatic int kind_of(input logic [4:0] op, output logic [3:0] alu);
        alu = 4'd0;
        if (op >= 5'd3 && op <= 5'd10) begin alu = 4'(op - 5'd3); return 0; end
        if (op == 5'd11) begin alu = 4'b0000; return 1; end
        if (op == 5'd12) begin alu = 4'b0110; return 1; end
        if (op == 5'd13) begin alu = 4'b0111; return 1; end
        if (op == 5'd15) begin alu = 4'b1000; return 2; end
        if (op == 5'd16) begin alu = 4'b1001; return 2; end
        if (op == 5'd17) begin alu = 4'b1010; return 3; end
        if (op == 5'd18) begin alu = 4'b1011; return 3; end
        if (op == 5'd26) return 4;
        if (op == 5'd27) return 5;
        return 6;
    endfunction

    // Expected strobes for one whole instruction with `stall` not-ready T1 cycles.
    function automatic void build_trace(input logic [31:0] ir, input int stall);
        vec_t        v;
        vec_t        b;
        logic [3:0]  alu;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        int          k;
        exp_q.delete();
        mr_q.delete();
        ra = ir[26:23];
        rb = ir[22:19];
        rc = ir[18:15];
        k  = kind_of(ir[31:27], alu);
        b  = '0;
        b.run = 1'b1;

        v = b; v.PCout = 1; v.MARin = 1; v.IncPC = 1; v.Zin = 1;
        exp_q.push_back(v); mr_q.push_back(1'($urandom));
        for (int s = 0; s <= stall; s++) begin
            v = b; v.ZLowout = 1; v.PCin = 1; v.Read = 1; v.MDRin = 1;
            exp_q.push_back(v); mr_q.push_back(s == stall);
        end
        v = b; v.MDRout = 1; v.IRin = 1;
        exp_q.push_back(v); mr_q.push_back(1'($urandom));

        case (k)
            0, 1: begin
                v = b; v.Rout = oh(rb); v.Yin = 1; exp_q.push_back(v);
                v = b; v.Zin = 1; v.alu = alu;
                if (k == 0) v.Rout = oh(rc); else v.Cout = 1;
                exp_q.push_back(v);
                v = b; v.ZLowout = 1; v.Rin = oh(ra); exp_q.push_back(v);
            end
            2: begin
                v = b; v.Rout = oh(ra); v.Yin = 1; exp_q.push_back(v);
                v = b; v.Rout = oh(rb); v.Zin = 1; v.alu = alu; exp_q.push_back(v);
                v = b; v.ZLowout = 1; v.LOin = 1; exp_q.push_back(v);
                v = b; v.ZHighout = 1; v.HIin = 1; exp_q.push_back(v);
            end
            3: begin
                v = b; v.Rout = oh(rb); v.Zin = 1; v.alu = alu; exp_q.push_back(v);
                v = b; v.ZLowout = 1; v.Rin = oh(ra); exp_q.push_back(v);
            end
            6: begin
                v = b; v.illegal = 1; exp_q.push_back(v);
            end
            default: exp_q.push_back(b);
        endcase
        while (mr_q.size() < exp_q.size()) mr_q.push_back(1'($urandom));
    endfunction

    // Per-cycle checks shared by every trace: exact strobes plus bus-driver rules.
    task automatic check_cycle(input string name, input int cyc, input vec_t e);
        vec_t o;
        o = sample();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, cyc, o, e);
        end
        checks++;
        if ($countones(o.Rin) > 1 || $countones(o.Rout) > 1) begin
            errors++;
            $display("FAIL %s onehot cycle %0d Rin %h Rout %h expected at most one bit", name, cyc, o.Rin, o.Rout);
        end
        checks++;
        if (|o.Rout && (o.PCout | o.MDRout | o.ZLowout | o.ZHighout | o.Cout)) begin
            errors++;
            $display("FAIL %s busdrv cycle %0d got %h expected single driver", name, cyc, o);
        end
        irin_cnt += int'(o.IRin);
        read_cnt += int'(o.Read);
        hiin_cnt += int'(o.HIin);
    endtask

    // Play the built trace; at cycle `cut` reset is asserted instead and the run stops.
    task automatic run_trace(input string name, input logic [31:0] ir, input int cut);
        vec_t e;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == 0) bus.IR = ir;
            reset         = (i == cut);
            bus.mem_ready = mr_q[i];
            @(negedge clk);
            e = (i == cut) ? vec_t'(0) : exp_q[i];
            check_cycle(name, i, e);
            if (i == cut) break;
        end
    endtask

    task automatic do_instr(input string name, input logic [31:0] ir, input int stall);
        build_trace(ir, stall);
        run_trace(name, ir, -1);
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.IR        = 32'hF8000000;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            bus.mem_ready = 1'($urandom);
            @(negedge clk);
            check_cycle("reset", i, vec_t'(0));
        end
    endtask

    task automatic test_directed();
        do_instr("and", 32'h4A920000, 0);
        do_instr("mul", 32'h79880000, 0);
        do_instr("addi", 32'h591FFFFB, 0);
        do_instr("neg", 32'h8A380000, 0);
        do_instr("nop", 32'hD0000000, 0);
        do_instr("illegal", 32'hF8000000, 0);
    endtask

    task automatic test_stall();
        irin_cnt = 0;
        read_cnt = 0;
        do_instr("stall", 32'h4A920000, 3);
        checks++;
        if (irin_cnt !== 1) begin
            errors++;
            $display("FAIL stall_irin got %0d expected 1", irin_cnt);
        end
        checks++;
        if (read_cnt !== 4) begin
            errors++;
            $display("FAIL stall_read got %0d expected 4", read_cnt);
        end
    endtask

    task automatic test_random();
        logic [4:0]  op;
        logic [31:0] ir;
        for (int n = 0; n < 60; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            ir = {op, 27'($urandom)};
            do_instr("random", ir, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_halt_reset();
        do_instr("halt", 32'hD8000000, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            bus.mem_ready = 1'($urandom);
            @(negedge clk);
            check_cycle("halted", i, vec_t'(0));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_cycle("halt_reset", 0, vec_t'(0));
        do_instr("after_halt", 32'h1A920000, 1);
    endtask

    task automatic test_reset_mid_mul();
        hiin_cnt = 0;
        build_trace(32'h79880000, 0);
        run_trace("mul_reset", 32'h79880000, 5);
        checks++;
        if (hiin_cnt !== 0) begin
            errors++;
            $display("FAIL mul_reset_hiin got %0d expected 0", hiin_cnt);
        end
        do_instr("after_mul_reset", 32'h4A920000, 0);
    endtask

    task automatic test_back_to_back();
        do_instr("b2b_div", 32'h81100000, 0);
        do_instr("b2b_not", 32'h92000000, 2);
        do_instr("b2b_ori", 32'h6FFC0001, 0);
        do_instr("b2b_rol", 32'h47FF8000, 0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        irin_cnt = 0;
        read_cnt = 0;
        hiin_cnt = 0;
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid_mul();
        test_halt_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
